// File: rtl/noc_axi_lite_slave_adapter.sv
// noc_axi_lite_slave_adapter
// Slave-side network adapter. It takes request flits from a router local port,
// replays each request as one AXI4-Lite transaction on a local slave, and sends
// a single HEAD_TAIL response flit back to the requesting node. Only one
// transaction is in flight at a time, and requests are served in arrival order.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   flit_in_*          request flits from the router (valid/ready)
//   flit_out_*         response flits to the router (valid/ready)
//   m_axi_aw*/w*/b*    AXI4-Lite write address / data / response channels
//   m_axi_ar*/r*       AXI4-Lite read address / data channels
module noc_axi_lite_slave_adapter #(
  parameter int                  ID_WIDTH   = 8,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [ID_WIDTH-1:0] LOCAL_ID   = 8'h00,
  localparam int                 FLIT_WIDTH = 4 + 2*ID_WIDTH + DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH-1:0]   flit_in_data,
  input  logic                    flit_in_valid,
  output logic                    flit_in_ready,
  output logic [FLIT_WIDTH-1:0]   flit_out_data,
  output logic                    flit_out_valid,
  input  logic                    flit_out_ready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam logic [1:0] TYPE_HEAD      = 2'b00;
  localparam logic [1:0] TYPE_BODY      = 2'b01;
  localparam logic [1:0] TYPE_TAIL      = 2'b10;
  localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;
  localparam logic [1:0] CMD_WR         = 2'b00;
  localparam logic [1:0] CMD_RD         = 2'b01;
  localparam logic [1:0] CMD_WRESP      = 2'b10;
  localparam logic [1:0] CMD_RRESP      = 2'b11;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_TAIL    = 3'd1,
    WR_ADDR_DATA = 3'd2,
    WR_RESP      = 3'd3,
    RD_ADDR      = 3'd4,
    RD_DATA      = 3'd5,
    SEND_RESP    = 3'd6
  } state_t;

  state_t                  state_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [FLIT_WIDTH-1:0]   out_data_r;
  logic [ID_WIDTH-1:0]     src_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    awvalid_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic                    arvalid_r;
  logic                    rready_r;

  logic [1:0]              in_type_s;
  logic [1:0]              in_cmd_s;
  logic [ID_WIDTH-1:0]     in_dest_s;
  logic [ID_WIDTH-1:0]     in_src_s;
  logic [DATA_WIDTH-1:0]   in_payload_s;
  logic                    in_fire_s;
  logic                    wr_head_s;
  logic                    rd_head_s;
  logic                    aw_done_s;
  logic                    w_done_s;
  logic                    unused_ok_s;

  assign in_type_s    = flit_in_data[FLIT_WIDTH-1 -: 2];
  assign in_cmd_s     = flit_in_data[FLIT_WIDTH-3 -: 2];
  assign in_dest_s    = flit_in_data[FLIT_WIDTH-5 -: ID_WIDTH];
  assign in_src_s     = flit_in_data[DATA_WIDTH+ID_WIDTH-1 -: ID_WIDTH];
  assign in_payload_s = flit_in_data[DATA_WIDTH-1:0];
  assign in_fire_s    = flit_in_valid & in_ready_r;

  // Only these two request shapes start a transaction; all else is dropped.
  assign wr_head_s = (in_type_s == TYPE_HEAD) && (in_cmd_s == CMD_WR) && (in_dest_s == LOCAL_ID);
  assign rd_head_s = (in_type_s == TYPE_HEAD_TAIL) && (in_cmd_s == CMD_RD) && (in_dest_s == LOCAL_ID);

  // A write channel is done once its valid has dropped or it handshakes now.
  assign aw_done_s = ~awvalid_r | m_axi_awready;
  assign w_done_s  = ~wvalid_r | m_axi_wready;

  // rresp is deliberately not carried in the response flit.
  assign unused_ok_s = ^m_axi_rresp;

  assign flit_in_ready  = in_ready_r;
  assign flit_out_valid = out_valid_r;
  assign flit_out_data  = out_data_r;
  assign m_axi_awaddr   = addr_r;
  assign m_axi_araddr   = addr_r;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_awvalid  = awvalid_r;
  assign m_axi_wvalid   = wvalid_r;
  assign m_axi_wdata    = wdata_r;
  assign m_axi_wstrb    = {(DATA_WIDTH/8){wvalid_r}};
  assign m_axi_bready   = bready_r;
  assign m_axi_arvalid  = arvalid_r;
  assign m_axi_rready   = rready_r;

  // Request/response sequencer with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      src_r       <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, WAIT_TAIL: begin
          if (in_fire_s) begin
            if ((state_r == WAIT_TAIL) && (in_type_s == TYPE_TAIL)) begin
              wdata_r    <= in_payload_s;
              awvalid_r  <= 1'b1;
              wvalid_r   <= 1'b1;
              in_ready_r <= 1'b0;
              state_r    <= WR_ADDR_DATA;
            end else if ((state_r == WAIT_TAIL) && (in_type_s == TYPE_BODY)) begin
              in_ready_r <= 1'b1;
              state_r    <= WAIT_TAIL;
            end else if (wr_head_s) begin
              // A new head while waiting for a tail abandons the old write.
              src_r      <= in_src_s;
              addr_r     <= in_payload_s[ADDR_WIDTH-1:0];
              in_ready_r <= 1'b1;
              state_r    <= WAIT_TAIL;
            end else if (rd_head_s) begin
              src_r      <= in_src_s;
              addr_r     <= in_payload_s[ADDR_WIDTH-1:0];
              arvalid_r  <= 1'b1;
              in_ready_r <= 1'b0;
              state_r    <= RD_ADDR;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= IDLE;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        WR_ADDR_DATA: begin
          if (awvalid_r && m_axi_awready) awvalid_r <= 1'b0;
          if (wvalid_r && m_axi_wready) wvalid_r <= 1'b0;
          if (aw_done_s && w_done_s) begin
            bready_r <= 1'b1;
            state_r  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_r    <= 1'b0;
            out_valid_r <= 1'b1;
            out_data_r  <= {TYPE_HEAD_TAIL, CMD_WRESP, src_r, LOCAL_ID,
                            {(DATA_WIDTH-2){1'b0}}, m_axi_bresp};
            state_r     <= SEND_RESP;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            rready_r    <= 1'b0;
            out_valid_r <= 1'b1;
            out_data_r  <= {TYPE_HEAD_TAIL, CMD_RRESP, src_r, LOCAL_ID, m_axi_rdata};
            state_r     <= SEND_RESP;
          end
        end
        SEND_RESP: begin
          if (flit_out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
